serial_full_sub: RTL and testbench
==================================

# serial_full_sub

Parametrised multi-cycle subtractor that computes A − B − BorrowIn over WIDTH/DIGIT clock cycles. Each cycle it processes DIGIT bits through a ripple of one-bit full subtractors and carries the borrow forward in a register. It is the sequential, width-generic successor to the one-bit full subtractor. It sits beside the combinational subtractors in the arithmetic library for area-constrained datapaths that can trade latency for gates.

## Interface
Parameters:
- WIDTH, default 8: operand and result width; must be ≥ 1.
- DIGIT, default 1: bits processed per cycle. Must divide WIDTH exactly; a non-divisor is an elaboration error.
- STEPS (localparam) = WIDTH/DIGIT: number of RUN cycles per operation.

Ports:
- clk, in, 1: single clock; all state updates on the rising edge.
- rst_n, in, 1: reset; asynchronous, active-low.
- Start, in, 1: request; sampled on a rising edge while Ready=1.
- Ready, out, 1: block can accept Start this cycle.
- A, in, WIDTH: minuend; captured when Start is accepted.
- B, in, WIDTH: subtrahend; captured when Start is accepted.
- BorrowIn, in, 1: initial borrow; captured when Start is accepted.
- Diff, out, WIDTH: (A − B − BorrowIn) mod 2^WIDTH.
- BorrowOut, out, 1: 1 iff A < B + BorrowIn (unsigned).
- Overflow, out, 1: two's-complement overflow, A[MSB]≠B[MSB] and Diff[MSB]≠A[MSB].
- Done, out, 1: one-cycle pulse; results valid and stable from this cycle.

## Operation
- States and transitions:
  - IDLE: Ready=1. Start=1 → RUN.
  - RUN: Ready=0. Start is ignored, with no queuing. Stays in RUN until the last digit has been processed → DONE.
  - DONE: Ready=1, Done=1. Start=1 → RUN back-to-back; otherwise → IDLE.
- On accept:
  - opA ← A, opB ← B, borrow ← BorrowIn, step ← 0.
  - The internal difference shift register is cleared.
- Each RUN cycle:
  - The digit sub-module subtracts opB[DIGIT-1:0] and borrow from opA[DIGIT-1:0].
  - The difference digit is shifted into the top of the shift register.
  - opA and opB shift right by DIGIT; borrow ← digit borrow-out; step increments.
- Last step (step = STEPS−1): Diff, BorrowOut and Overflow update on the same edge that enters DONE.
- Diff, BorrowOut and Overflow hold their values until the next operation completes. They do not change during RUN.
- Operand inputs may change freely after accept without affecting the result.
- step counter width is max(1, $clog2(STEPS)). For STEPS=1 the block spends one cycle in RUN.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, Ready=1, Done=0, Diff=0, BorrowOut=0, Overflow=0, internal registers 0.
- Reset mid-RUN aborts the operation. No Done is produced, and the outputs read 0.
- Latency: Start accepted at edge E0 → Done=1 in the cycle following edge E_STEPS.
- Throughput: one result per STEPS+1 cycles when Start is held high. Start in the DONE cycle is accepted, so the next Done comes STEPS+1 cycles after the previous one.
- Ready is combinational from state only and never depends on Start.

## Structure
- Shared package sub_pkg holds:
  - state encodings S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2;
  - a function checking that DIGIT divides WIDTH, used by an elaboration assertion.
- One natural sub-module, digit_full_sub (parameter DIGIT):
  - purely combinational ripple of DIGIT one-bit full subtractors;
  - ports A, B, BorrowIn, Diff, BorrowOut.
- The top level contains the FSM, step counter, operand shift registers, borrow register and output registers.

## Test plan
- WIDTH=8, DIGIT=1; A=0x05, B=0x03, BorrowIn=0 → Done after 8 RUN cycles; Diff=0x02, BorrowOut=0, Overflow=0.
- A=0x00, B=0x01, BorrowIn=0 → Diff=0xFF, BorrowOut=1, Overflow=0. Then A=0x00, B=0xFF, BorrowIn=1 → Diff=0x00, BorrowOut=1.
- A=0x80, B=0x01, BorrowIn=0 → Diff=0x7F, BorrowOut=0, Overflow=1. Also A=0x7F, B=0xFF → Diff=0x80, BorrowOut=1, Overflow=1.
- Start pulsed again mid-RUN with different operands → ignored; the first result is delivered unchanged.
- Start held high for 3 operations → Done every 9 cycles and each result is correct.
- rst_n dropped at RUN step 4 → immediate IDLE with all outputs 0 and no Done. A fresh operation then completes normally.
- Exhaustive sweep against a reference model, WIDTH=4 with DIGIT ∈ {1, 2, 4}: all 512 combinations of A, B and BorrowIn match A − B − BorrowIn, BorrowOut and Overflow. DIGIT=4 gives Done one cycle after RUN.

Source files
------------

// File: rtl/sub_pkg.sv
// Shared definitions for the serial subtractor family: FSM encodings and
// parameter legality helpers.
package sub_pkg;

  // FSM encodings (kept as plain constants for legacy tools)
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // True when a digit of `digit` bits tiles a word of `width` bits exactly.
  function automatic bit digitDivides(input int unsigned width, input int unsigned digit);
    return (digit != 0) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/digit_full_sub.sv
// Combinational DIGIT-bit subtractor: a ripple of one-bit full subtractors
// computing A - B - BorrowIn with the borrow propagating LSB to MSB.
module digit_full_sub #(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] A,
  input  logic [DIGIT-1:0] B,
  input  logic             BorrowIn,
  output logic [DIGIT-1:0] Diff,
  output logic             BorrowOut
);

  // borrowChain[i] is the borrow into bit i
  logic [DIGIT:0] borrowChain;

  assign borrowChain[0] = BorrowIn;

  for (genvar i = 0; i < DIGIT; i++) begin : gBit
    assign Diff[i] = A[i] ^ B[i] ^ borrowChain[i];
    // Borrow when b > a, or when a == b and a borrow is already pending
    assign borrowChain[i+1] = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & borrowChain[i]);
  end

  assign BorrowOut = borrowChain[DIGIT];

endmodule

// File: rtl/serial_full_sub.sv
// Multi-cycle subtractor: computes A - B - BorrowIn over WIDTH/DIGIT cycles,
// DIGIT bits per cycle, carrying the borrow between cycles in a register.
module serial_full_sub
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  output logic             Ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BorrowIn,
  output logic [WIDTH-1:0] Diff,
  output logic             BorrowOut,
  output logic             Overflow,
  output logic             Done
);

  localparam int unsigned STEPS = WIDTH / DIGIT;
  localparam int unsigned StepW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [StepW-1:0] LastStep = StepW'(STEPS - 1);

  // Reject illegal parameterisations at elaboration time
  if ((WIDTH < 1) || !digitDivides(WIDTH, DIGIT)) begin : gParamCheck
    $error("serial_full_sub: DIGIT must divide WIDTH and WIDTH must be >= 1");
  end

  logic [1:0]       state_q, state_d;
  logic [StepW-1:0] step_q, step_d;
  logic [WIDTH-1:0] opA_q, opA_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic             borrow_q, borrow_d;
  // Operand sign bits are kept aside because the operand registers shift away
  logic             aMsb_q, aMsb_d;
  logic             bMsb_q, bMsb_d;
  logic [WIDTH-1:0] diffSr_q, diffSr_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrowOut_q, borrowOut_d;
  logic             overflow_q, overflow_d;

  logic [DIGIT-1:0] digitDiff;
  logic             digitBorrow;
  logic [WIDTH-1:0] diffNext;
  logic             accept;
  logic             lastStep;

  digit_full_sub #(
    .DIGIT(DIGIT)
  ) uDigit (
    .A        (opA_q[DIGIT-1:0]),
    .B        (opB_q[DIGIT-1:0]),
    .BorrowIn (borrow_q),
    .Diff     (digitDiff),
    .BorrowOut(digitBorrow)
  );

  // Status decoded from state alone; Ready never looks at Start
  always_comb begin
    Ready = (state_q != S_RUN);
    Done  = (state_q == S_DONE);
  end

  // Shift-register view after this cycle's digit enters at the top
  always_comb begin
    diffNext = WIDTH'({digitDiff, diffSr_q} >> DIGIT);
    accept   = Ready & Start;
    lastStep = (step_q == LastStep);
  end

  // Next-state logic: FSM, operand shifting, borrow chaining, result capture
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    opA_d       = opA_q;
    opB_d       = opB_q;
    borrow_d    = borrow_q;
    aMsb_d      = aMsb_q;
    bMsb_d      = bMsb_q;
    diffSr_d    = diffSr_q;
    diff_d      = diff_q;
    borrowOut_d = borrowOut_q;
    overflow_d  = overflow_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_d  = S_RUN;
          step_d   = '0;
          opA_d    = A;
          opB_d    = B;
          borrow_d = BorrowIn;
          aMsb_d   = A[WIDTH-1];
          bMsb_d   = B[WIDTH-1];
          diffSr_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        opA_d    = opA_q >> DIGIT;
        opB_d    = opB_q >> DIGIT;
        borrow_d = digitBorrow;
        diffSr_d = diffNext;
        step_d   = step_q + StepW'(1);
        if (lastStep) begin
          state_d     = S_DONE;
          step_d      = '0;
          diff_d      = diffNext;
          borrowOut_d = digitBorrow;
          overflow_d  = (aMsb_q ^ bMsb_q) & (diffNext[WIDTH-1] ^ aMsb_q);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any operation in flight and zeroes results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      step_q      <= '0;
      opA_q       <= '0;
      opB_q       <= '0;
      borrow_q    <= 1'b0;
      aMsb_q      <= 1'b0;
      bMsb_q      <= 1'b0;
      diffSr_q    <= '0;
      diff_q      <= '0;
      borrowOut_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      opA_q       <= opA_d;
      opB_q       <= opB_d;
      borrow_q    <= borrow_d;
      aMsb_q      <= aMsb_d;
      bMsb_q      <= bMsb_d;
      diffSr_q    <= diffSr_d;
      diff_q      <= diff_d;
      borrowOut_q <= borrowOut_d;
      overflow_q  <= overflow_d;
    end
  end

  assign Diff      = diff_q;
  assign BorrowOut = borrowOut_q;
  assign Overflow  = overflow_q;

endmodule

// File: tb/tb_serial_full_sub.sv
// Self-checking bench for serial_full_sub: directed 8-bit vectors, multi-cycle
// corner cases, and an exhaustive 4-bit sweep over DIGIT = 1, 2, 4.
module tb_serial_full_sub;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 8-bit, one bit per cycle
  logic       start, bin;
  logic [7:0] a, b;
  logic       ready, bo, ov, done;
  logic [7:0] diff;

  serial_full_sub #(
    .WIDTH(8),
    .DIGIT(1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Start    (start),
    .Ready    (ready),
    .A        (a),
    .B        (b),
    .BorrowIn (bin),
    .Diff     (diff),
    .BorrowOut(bo),
    .Overflow (ov),
    .Done     (done)
  );

  // 4-bit instances sharing stimulus, DIGIT = 1 << g
  logic            sStart, sBin;
  logic [3:0]      sA, sB;
  logic [2:0]      wReady, wDone, wBo, wOv;
  logic [2:0][3:0] wDiff;

  for (genvar g = 0; g < 3; g++) begin : gW4
    serial_full_sub #(
      .WIDTH(4),
      .DIGIT(1 << g)
    ) dutW4 (
      .clk      (clk),
      .rst_n    (rst_n),
      .Start    (sStart),
      .Ready    (wReady[g]),
      .A        (sA),
      .B        (sB),
      .BorrowIn (sBin),
      .Diff     (wDiff[g]),
      .BorrowOut(wBo[g]),
      .Overflow (wOv[g]),
      .Done     (wDone[g])
    );
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } vec_t;

  vec_t vecs[7];
  int   checks = 0;
  int   errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // One complete operation on the 8-bit DUT with latency, hold and pulse checks
  task automatic runMain(input vec_t v, input string name);
    logic [7:0] prevDiff;
    int         lat;
    bit         stable;
    for (int i = 0; i < 20 && !ready; i++) tick();
    check({name, " ready"}, 32'(ready), 32'd1);
    a = v.a; b = v.b; bin = v.bin; start = 1'b1;
    tick();
    start = 1'b0;
    // Operand inputs are scrambled after accept; the result must not care
    a = ~v.a; b = 8'h5A; bin = ~v.bin;
    prevDiff = diff;
    lat = 0;
    stable = 1'b1;
    while (!done && lat < 20) begin
      tick();
      lat++;
      if (!done && diff !== prevDiff) stable = 1'b0;
    end
    check({name, " latency"}, 32'(lat), 32'd8);
    check({name, " diff"}, 32'(diff), 32'(v.d));
    check({name, " borrow"}, 32'(bo), 32'(v.bo));
    check({name, " overflow"}, 32'(ov), 32'(v.ov));
    check({name, " hold during run"}, 32'(stable), 32'd1);
    tick();
    check({name, " done pulse"}, 32'(done), 32'd0);
  endtask

  // Global bound so the run can never hang
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] prevDiff;
    int         lat, k, lastDone;
    bit         sawDone, stable;
    logic [3:0] ea, eb, ed;
    logic       eBin, eBo, eOv;
    logic [7:0] gotLat[3];
    logic [5:0] got[3];

    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[5] = '{8'hA5, 8'h5A, 1'b1, 8'h4A, 1'b0, 1'b1};
    vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

    rst_n = 1'b0;
    start = 1'b0; a = '0; b = '0; bin = 1'b0;
    sStart = 1'b0; sA = '0; sB = '0; sBin = 1'b0;
    #12;
    check("reset ready", 32'(ready), 32'd1);
    check("reset done", 32'(done), 32'd0);
    check("reset diff", 32'(diff), 32'd0);
    check("reset borrow", 32'(bo), 32'd0);
    check("reset overflow", 32'(ov), 32'd0);
    check("reset w4 ready", 32'(wReady), 32'd7);
    tick();
    rst_n = 1'b1;
    tick();

    // Directed table
    for (int i = 0; i < 7; i++) runMain(vecs[i], $sformatf("vec%0d", i));

    // Start pulsed mid-RUN with other operands must be ignored
    a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    prevDiff = diff;
    repeat (3) tick();
    check("midrun ready low", 32'(ready), 32'd0);
    a = 8'h11; b = 8'h22; bin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 4;
    stable = 1'b1;
    while (!done && lat < 20) begin
      tick();
      lat++;
      if (!done && diff !== prevDiff) stable = 1'b0;
    end
    check("midrun latency", 32'(lat), 32'd8);
    check("midrun diff", 32'(diff), 32'h02);
    check("midrun borrow", 32'(bo), 32'd0);
    check("midrun hold", 32'(stable), 32'd1);
    tick();
    check("midrun no requeue", 32'(ready), 32'd1);
    check("midrun done pulse", 32'(done), 32'd0);

    // Start held high for three back-to-back operations
    k = 0;
    lastDone = 0;
    a = vecs[3].a; b = vecs[3].b; bin = vecs[3].bin; start = 1'b1;
    tick();
    for (int t = 1; t <= 40 && k < 3; t++) begin
      tick();
      if (done) begin
        check($sformatf("held%0d diff", k), 32'(diff), 32'(vecs[k+3].d));
        check($sformatf("held%0d borrow", k), 32'(bo), 32'(vecs[k+3].bo));
        check($sformatf("held%0d overflow", k), 32'(ov), 32'(vecs[k+3].ov));
        check($sformatf("held%0d spacing", k), 32'(t - lastDone), (k == 0) ? 32'd8 : 32'd9);
        lastDone = t;
        k++;
        if (k == 3) begin
          start = 1'b0;
        end else begin
          a = vecs[k+3].a; b = vecs[k+3].b; bin = vecs[k+3].bin;
        end
      end
    end
    start = 1'b0;
    check("held count", 32'(k), 32'd3);
    tick();
    check("held back to idle", 32'(ready & ~done), 32'd1);

    // Reset at RUN step 4
    a = 8'h55; b = 8'h22; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("prereset busy", 32'(ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("abort ready", 32'(ready), 32'd1);
    check("abort done", 32'(done), 32'd0);
    check("abort diff", 32'(diff), 32'd0);
    check("abort borrow", 32'(bo), 32'd0);
    check("abort overflow", 32'(ov), 32'd0);
    tick();
    rst_n = 1'b1;
    sawDone = 1'b0;
    repeat (12) begin
      tick();
      if (done) sawDone = 1'b1;
    end
    check("abort no done", 32'(sawDone), 32'd0);
    runMain(vecs[0], "after abort");

    // Exhaustive 4-bit sweep on DIGIT = 1, 2, 4
    for (int c = 0; c < 512; c++) begin
      ea = 4'(c);
      eb = 4'(c >> 4);
      eBin = c[8];
      ed = ea - eb - 4'(eBin);
      eBo = ({1'b0, ea} < ({1'b0, eb} + 5'(eBin)));
      eOv = (ea[3] != eb[3]) && (ed[3] != ea[3]);
      sA = ea; sB = eb; sBin = eBin; sStart = 1'b1;
      tick();
      sStart = 1'b0;
      for (int g = 0; g < 3; g++) begin
        gotLat[g] = 8'hFF;
        got[g] = '0;
      end
      for (int t = 1; t <= 5; t++) begin
        tick();
        for (int g = 0; g < 3; g++) begin
          if (wDone[g] && gotLat[g] == 8'hFF) begin
            gotLat[g] = 8'(t);
            got[g] = {wDiff[g], wBo[g], wOv[g]};
          end
        end
      end
      for (int g = 0; g < 3; g++) begin
        check($sformatf("w4 digit%0d a%0h b%0h bin%0d latency", 1 << g, ea, eb, eBin),
              32'(gotLat[g]), 32'(4 >> g));
        check($sformatf("w4 digit%0d a%0h b%0h bin%0d result", 1 << g, ea, eb, eBin),
              32'(got[g]), 32'({ed, eBo, eOv}));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
